axi_sram_slave: RTL and testbench

// AXI3 slave that ends the bus driven by cpu_axi_interface: it answers AR/R and AW/W/B with a word-wide on-chip RAM.

---
 rtl/axi_sram_slave.sv | 225 ++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-wide on-chip RAM. One transaction (read or
// write) is in flight at a time; INCR and FIXED bursts up to 16 beats.
// WRAP and reserved burst types are served as INCR but answered SLVERR.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | no transaction; arbitrate AR vs AW (round-robin on collision)
//   S_RD   | read burst: rvalid held, one beat per rvalid&&rready
//   S_WR   | write burst: wready high, one RAM write per wvalid&&wready
//   S_WB   | write response: bvalid held until bready
module axi_sram_slave #(
    parameter int ADDR_W    = 10,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic        aclk_i,
    input  logic        aresetn_i,
    input  logic [3:0]  arid_i,
    input  logic [31:0] araddr_i,
    input  logic [7:0]  arlen_i,
    input  logic [2:0]  arsize_i,
    input  logic [1:0]  arburst_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [3:0]  rid_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rlast_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    input  logic [3:0]  awid_i,
    input  logic [31:0] awaddr_i,
    input  logic [7:0]  awlen_i,
    input  logic [2:0]  awsize_i,
    input  logic [1:0]  awburst_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [3:0]  wid_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wlast_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [3:0]  bid_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i
);

    localparam int         DEPTH       = 1 << ADDR_W;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic       GRANT_RD    = 1'b0;
    localparam logic       GRANT_WR    = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WB} state_t;

    state_t              state_q, state_d;
    logic                last_grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          cnt_q;
    logic [1:0]          burst_q;
    logic                err_q;
    logic                rvalid_q, rlast_q;
    logic [31:0]         rdata_q;
    logic [1:0]          rresp_q, bresp_q;
    logic [3:0]          rid_q, bid_q;
    logic                bvalid_q;

    // No reset on the RAM: contents survive aresetn. With INIT_ZERO the
    // design relies on the simulator's zeroed power-up state.
    logic [31:0]         mem_q [DEPTH];

    logic                grant_rd, grant_wr;
    logic                ar_fire, aw_fire, r_fire, w_fire, b_fire;
    logic [ADDR_W-1:0]   ar_word, aw_word;

    // Address bits above the RAM, sizes and wid do not influence behaviour.
    logic unused_ok;
    assign unused_ok = ^{arsize_i, awsize_i, wid_i, INIT_ZERO,
                         araddr_i[31:ADDR_W+2], araddr_i[1:0], arlen_i[7:4],
                         awaddr_i[31:ADDR_W+2], awaddr_i[1:0], awlen_i[7:4]};

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [1:0]        burst);
        return (burst == BURST_FIXED) ? a : a + ADDR_W'(1);
    endfunction

    assign ar_word  = araddr_i[ADDR_W+1:2];
    assign aw_word  = awaddr_i[ADDR_W+1:2];
    assign grant_rd = arvalid_i && (!awvalid_i || last_grant_q == GRANT_WR);
    assign grant_wr = awvalid_i && (!arvalid_i || last_grant_q == GRANT_RD);

    assign ar_fire = arvalid_i && arready_o;
    assign aw_fire = awvalid_i && awready_o;
    assign r_fire  = rvalid_q && rready_i;
    assign w_fire  = wvalid_i && wready_o;
    assign b_fire  = bvalid_q && bready_i;

    assign rid_o    = rid_q;
    assign rdata_o  = rdata_q;
    assign rresp_o  = rresp_q;
    assign rlast_o  = rlast_q;
    assign rvalid_o = rvalid_q;
    assign bid_o    = bid_q;
    assign bresp_o  = bresp_q;
    assign bvalid_o = bvalid_q;

    // Next-state and ready outputs; readies are held low while in reset.
    always_comb begin
        state_d   = state_q;
        arready_o = 1'b0;
        awready_o = 1'b0;
        wready_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_rd) begin
                    arready_o = 1'b1;
                    state_d   = S_RD;
                end else if (grant_wr) begin
                    awready_o = 1'b1;
                    state_d   = S_WR;
                end
            end
            S_RD: begin
                if (r_fire && rlast_q) state_d = S_IDLE;
            end
            S_WR: begin
                wready_o = 1'b1;
                if (wvalid_i && cnt_q == 4'd0) state_d = S_WB;
            end
            S_WB: begin
                if (b_fire) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (!aresetn_i) begin
            arready_o = 1'b0;
            awready_o = 1'b0;
            wready_o  = 1'b0;
        end
    end

    // State register and burst datapath; cnt_q counts remaining beats down to 0.
    always_ff @(posedge aclk_i) begin
        if (!aresetn_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= GRANT_WR;
            addr_q       <= '0;
            cnt_q        <= '0;
            burst_q      <= '0;
            err_q        <= 1'b0;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            rid_q        <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            bid_q        <= '0;
        end else begin
            state_q <= state_d;

            if (ar_fire) begin
                if (awvalid_i) last_grant_q <= GRANT_RD;
                rid_q    <= arid_i;
                burst_q  <= arburst_i;
                cnt_q    <= arlen_i[3:0];
                rdata_q  <= mem_q[ar_word];
                addr_q   <= next_addr(ar_word, arburst_i);
                rvalid_q <= 1'b1;
                rlast_q  <= (arlen_i[3:0] == 4'd0);
                rresp_q  <= arburst_i[1] ? RESP_SLVERR : RESP_OKAY;
            end

            if (r_fire) begin
                if (rlast_q) begin
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                end else begin
                    rdata_q <= mem_q[addr_q];
                    addr_q  <= next_addr(addr_q, burst_q);
                    cnt_q   <= cnt_q - 4'd1;
                    rlast_q <= (cnt_q == 4'd1);
                end
            end

            if (aw_fire) begin
                if (arvalid_i) last_grant_q <= GRANT_WR;
                bid_q   <= awid_i;
                burst_q <= awburst_i;
                cnt_q   <= awlen_i[3:0];
                addr_q  <= aw_word;
                err_q   <= 1'b0;
            end

            if (w_fire) begin
                addr_q <= next_addr(addr_q, burst_q);
                if (cnt_q == 4'd0) begin
                    bvalid_q <= 1'b1;
                    err_q    <= err_q | ~wlast_i;
                    bresp_q  <= (err_q || !wlast_i || burst_q[1]) ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                    if (wlast_i) err_q <= 1'b1;
                end
            end

            if (b_fire) begin
                bvalid_q <= 1'b0;
                err_q    <= 1'b0;
            end
        end
    end

    // Byte-lane masked RAM write.
    always_ff @(posedge aclk_i) begin
        if (w_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_i[i]) mem_q[addr_q][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomised self-checking bench for axi_sram_slave against a byte-level
// memory model with per-byte "known" tracking and a round-robin grant model.
module tb_axi_sram_slave;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BOUND  = 200;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  arid = '0, awid = '0, wid = '0;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic [7:0]  arlen = '0, awlen = '0;
    logic [2:0]  arsize = 3'd2, awsize = 3'd2;
    logic [1:0]  arburst = '0, awburst = '0;
    logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic        rready = 1'b0, bready = 1'b0;
    logic [3:0]  wstrb = '0;
    logic        arready, awready, wready, rvalid, rlast, bvalid;
    logic [3:0]  rid, bid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    always #5 clk = ~clk;

    axi_sram_slave #(.ADDR_W(ADDR_W), .INIT_ZERO(1'b1)) dut (
        .aclk_i(clk), .aresetn_i(aresetn),
        .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize),
        .arburst_i(arburst), .arvalid_i(arvalid), .arready_o(arready),
        .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
        .rvalid_o(rvalid), .rready_i(rready),
        .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize),
        .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready),
        .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
        .wvalid_i(wvalid), .wready_o(wready),
        .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mdl   [DEPTH];
    logic [3:0]  kmask [DEPTH];
    bit          last_wr = 1'b1;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic int beat_addr(input int base, input int k, input logic [1:0] burst);
        return (burst == 2'b00) ? base : (base + k) % DEPTH;
    endfunction

    task automatic rd_addr(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int   cyc = 0;
        logic got = 1'b0;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        while (!got && cyc < BOUND) begin
            @(negedge clk); got = arready;
            @(posedge clk); #1; cyc++;
        end
        arvalid = 1'b0;
        chk("ar_accept", got, 1);
    endtask

    task automatic wr_addr(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int   cyc = 0;
        logic got = 1'b0;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        while (!got && cyc < BOUND) begin
            @(negedge clk); got = awready;
            @(posedge clk); #1; cyc++;
        end
        awvalid = 1'b0;
        chk("aw_accept", got, 1);
    endtask

    // mode 1: rready toggles 1,0,1,...; mode 0: random. stop_at>=0 leaves early.
    task automatic rd_data(input logic [3:0] id, input int base, input int len,
                           input logic [1:0] burst, input int mode, input int stop_at);
        int          k = 0, cyc = 0, a;
        logic [31:0] m;
        while (k <= len && cyc < BOUND) begin
            if (stop_at >= 0 && k == stop_at) break;
            rready = (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            a = beat_addr(base, k, burst);
            m = {{8{kmask[a][3]}}, {8{kmask[a][2]}}, {8{kmask[a][1]}}, {8{kmask[a][0]}}};
            chk("r_valid", rvalid, 1);
            if (kmask[a] != 4'b0) chk("r_data", rdata & m, mdl[a] & m);
            chk("r_resp", rresp, burst[1] ? 32'd2 : 32'd0);
            chk("r_id", rid, id);
            chk("r_last", rlast, k == len);
            if (rvalid && rready) k++;
            @(posedge clk); #1; cyc++;
        end
        rready = 1'b0;
        if (stop_at < 0) begin
            chk("r_beats", k, len + 1);
            @(negedge clk); chk("r_idle", rvalid, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic wr_data(input logic [3:0] id, input int base, input int len,
                           input logic [1:0] burst, input int wlast_pos, input int stop_at);
        int   k = 0, cyc = 0, a;
        logic got = 1'b0;
        bit   err;
        while (k <= len && cyc < BOUND) begin
            if (stop_at >= 0 && k == stop_at) break;
            wvalid = ($urandom_range(0, 3) != 0);
            wdata = wd[k]; wstrb = ws[k]; wlast = (k == wlast_pos);
            @(negedge clk);
            chk("w_ready", wready, 1);
            if (wvalid && wready) begin
                a = beat_addr(base, k, burst);
                for (int i = 0; i < 4; i++) begin
                    if (ws[k][i]) begin
                        mdl[a][8*i +: 8] = wd[k][8*i +: 8];
                        kmask[a][i] = 1'b1;
                    end
                end
                k++;
            end
            @(posedge clk); #1; cyc++;
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (stop_at >= 0) return;
        chk("w_beats", k, len + 1);
        err = (wlast_pos != len) || burst[1];
        @(negedge clk); chk("w_ready_off", wready, 0);
        @(posedge clk); #1;
        cyc = 0;
        while (!got && cyc < BOUND) begin
            bready = $urandom_range(0, 1);
            @(negedge clk);
            chk("b_valid", bvalid, 1);
            chk("b_id", bid, id);
            chk("b_resp", bresp, err ? 32'd2 : 32'd0);
            got = bready && bvalid;
            @(posedge clk); #1; cyc++;
        end
        bready = 1'b0;
        chk("b_done", got, 1);
        @(negedge clk); chk("b_idle", bvalid, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int wlast_pos);
        wr_addr(id, addr, len, burst);
        wr_data(id, word_of(addr), int'(len[3:0]), burst, wlast_pos, -1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int mode);
        rd_addr(id, addr, len, burst);
        rd_data(id, word_of(addr), int'(len[3:0]), burst, mode, -1);
    endtask

    task automatic collide(input logic [31:0] raddr, input logic [7:0] rlen, input logic [1:0] rburst,
                           input logic [31:0] waddr, input logic [7:0] wlen, input logic [1:0] wburst);
        bit exp_rd;
        exp_rd = last_wr;
        arid = 4'h3; araddr = raddr; arlen = rlen; arburst = rburst; arvalid = 1'b1;
        awid = 4'h5; awaddr = waddr; awlen = wlen; awburst = wburst; awvalid = 1'b1;
        @(negedge clk);
        chk("grant_ar", arready, exp_rd);
        chk("grant_aw", awready, !exp_rd);
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0;
        last_wr = !exp_rd;
        if (exp_rd) begin
            rd_data(4'h3, word_of(raddr), int'(rlen[3:0]), rburst, 0, -1);
            do_write(4'h5, waddr, wlen, wburst, int'(wlen[3:0]));
        end else begin
            wr_data(4'h5, word_of(waddr), int'(wlen[3:0]), wburst, int'(wlen[3:0]), -1);
            do_read(4'h3, raddr, rlen, rburst, 0);
        end
    endtask

    task automatic fill_wd();
        for (int i = 0; i < 16; i++) begin
            wd[i] = $urandom;
            ws[i] = 4'hF;
        end
    endtask

    task automatic pulse_reset();
        aresetn = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        last_wr = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mdl[i] = '0;
            kmask[i] = 4'b0;
        end

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", arready, 0);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ids", {rid, bid}, 0);
        chk("rst_resps", {rresp, bresp}, 0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(posedge clk); #1;

        // single write / read, then byte strobes
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(4'hA, 32'h10, 8'd0, 2'b01, 0);
        do_read(4'h6, 32'h10, 8'd0, 2'b01, 0);
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        do_write(4'h2, 32'h10, 8'd0, 2'b01, 0);
        do_read(4'h7, 32'h10, 8'd0, 2'b01, 0);

        // INCR read with toggling rready
        fill_wd();
        do_write(4'h1, 32'h20, 8'd3, 2'b01, 3);
        do_read(4'h9, 32'h20, 8'd3, 2'b01, 1);

        // two collisions: read first, then write first
        fill_wd();
        collide(32'h20, 8'd1, 2'b01, 32'h60, 8'd2, 2'b01);
        fill_wd();
        collide(32'h60, 8'd2, 2'b01, 32'h70, 8'd0, 2'b01);

        // wlast early, wlast late, WRAP read, FIXED burst
        fill_wd();
        do_write(4'hC, 32'h100, 8'd1, 2'b01, 0);
        do_write(4'hD, 32'h110, 8'd2, 2'b01, 16);
        do_read(4'hE, 32'h20, 8'd3, 2'b10, 0);
        fill_wd();
        do_write(4'h4, 32'h30, 8'd3, 2'b00, 3);
        do_read(4'h4, 32'h30, 8'd2, 2'b00, 0);

        // reset during beat 2 of a 4-beat read
        fill_wd();
        do_write(4'h8, 32'h40, 8'd3, 2'b01, 3);
        rd_addr(4'hB, 32'h40, 8'd3, 2'b01);
        rd_data(4'hB, word_of(32'h40), 3, 2'b01, 0, 2);
        pulse_reset();
        @(negedge clk);
        chk("rrst_rvalid", rvalid, 0);
        chk("rrst_arready", arready, 0);
        chk("rrst_rid", rid, 0);
        @(posedge clk); #1;
        do_read(4'hB, 32'h40, 8'd3, 2'b01, 0);

        // reset mid write burst keeps the beats already written
        fill_wd();
        do_write(4'h8, 32'h80, 8'd3, 2'b01, 3);
        fill_wd();
        wr_addr(4'h9, 32'h80, 8'd3, 2'b01);
        wr_data(4'h9, word_of(32'h80), 3, 2'b01, 3, 2);
        pulse_reset();
        @(negedge clk);
        chk("wrst_bvalid", bvalid, 0);
        chk("wrst_wready", wready, 0);
        @(posedge clk); #1;
        do_read(4'h1, 32'h80, 8'd3, 2'b01, 0);

        // random traffic
        for (int t = 0; t < 40; t++) begin
            int          op, w1, w2, lp;
            logic [31:0] a1, a2;
            logic [7:0]  l1, l2;
            logic [1:0]  b1, b2;
            op = $urandom_range(0, 4);
            w1 = ($urandom_range(0, 1) != 0) ? $urandom_range(DEPTH - 8, DEPTH - 1) : $urandom_range(0, 31);
            w2 = ($urandom_range(0, 1) != 0) ? $urandom_range(DEPTH - 8, DEPTH - 1) : $urandom_range(0, 31);
            a1 = ($urandom & 32'hFFFF_F003) | (32'(w1) << 2);
            a2 = ($urandom & 32'hFFFF_F003) | (32'(w2) << 2);
            l1 = 8'($urandom_range(0, 255));
            l2 = 8'($urandom_range(0, 255));
            b1 = 2'($urandom_range(0, 3));
            b2 = 2'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) begin
                wd[i] = $urandom;
                ws[i] = 4'($urandom_range(0, 15));
            end
            lp = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 16) : int'(l1[3:0]);
            if (op <= 1)      do_write(4'($urandom_range(0, 15)), a1, l1, b1, lp);
            else if (op <= 3) do_read(4'($urandom_range(0, 15)), a1, l1, b1, 0);
            else              collide(a1, l1, b1, a2, l2, b2);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
